uart_rx_core: RTL and testbench

//  UART receiver, 8N1 framing, LSB first: 1 start bit (low), UART_DATA_LENGTH data bits, 1 stop bit (high).

---
 rtl/uart_rx_core.sv | 118 +++++++++++
 tb/tb_uart_rx_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 UART receiver (start low, data LSB first, stop high).
// The serial line is brought in through a 2-flop synchronizer. The FSM times
// each bit with a baud counter and samples at mid-bit. Each good frame updates
// data_o and raises a one-cycle strobe.
// Ports:
//   clk_i              system clock, rising edge
//   reset_i            synchronous active-high reset
//   rx_i               asynchronous serial input, idle high
//   data_o             last correctly framed byte, bit0 = first data bit
//   data_valid_strb_o  one-cycle pulse when data_o is updated
module uart_rx_core #(
  parameter int UART_BAUD_RATE             = 19200,
  parameter int UART_DATA_LENGTH           = 8,
  parameter int CLK_FREQ                   = 10000000,
  parameter int RX_COUNTER_BITWIDTH        = 3,
  parameter int BAUD_COUNTS_PER_BIT        = 521,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rx_i,
  output logic [UART_DATA_LENGTH-1:0] data_o,
  output logic                        data_valid_strb_o
);

  localparam int HALF = BAUD_COUNTS_PER_BIT / 2;

  // Terminal values, sized to the counters so every compare is width-exact.
  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] HALF_TERM =
    BAUD_RATE_COUNTER_BITWIDTH'(HALF - 1);
  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BIT_TERM =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
  localparam logic [RX_COUNTER_BITWIDTH-1:0] LAST_IDX =
    RX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);

  // Elaboration-time sanity check on the timing parameters.
  if (UART_BAUD_RATE < 1 || CLK_FREQ < UART_BAUD_RATE || BAUD_COUNTS_PER_BIT < 2)
  begin : g_bad_cfg
    $error("uart_rx_core: inconsistent baud/clock parameters");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                                state;
  logic                                  rx_meta;
  logic                                  rxs;
  logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] cnt;
  logic [RX_COUNTER_BITWIDTH-1:0]        idx;
  logic [UART_DATA_LENGTH-1:0]           shreg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      rx_meta           <= 1'b1;
      rxs               <= 1'b1;
      cnt               <= '0;
      idx               <= '0;
      shreg             <= '0;
      data_o            <= '0;
      data_valid_strb_o <= 1'b0;
    end else begin
      rx_meta           <= rx_i;
      rxs               <= rx_meta;
      data_valid_strb_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        // Re-check the line at mid start bit. A short low pulse is treated
        // as noise and dropped here.
        START: begin
          if (cnt == HALF_TERM) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A full bit period after the mid start bit lands on each data bit's middle.
        DATA: begin
          if (cnt == BIT_TERM) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == LAST_IDX) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leave at mid stop bit so a start bit that follows right away is caught.
        STOP: begin
          if (cnt == BIT_TERM) begin
            cnt <= '0;
            if (rxs) begin
              data_o            <= shreg;
              data_valid_strb_o <= 1'b1;
              state             <= IDLE;
            end else begin
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // After a framing error or break, wait for the line to go high again.
        // Without this, a line held low would start a new frame straight away.
        WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- scoreboard bench for uart_rx_core.
// The bit period is scaled to 52 clocks (1 MHz clock at 19200 baud) to keep
// run time short. Expected bytes are queued as frames are driven. A negedge
// monitor pops and compares them on every strobe.
module tb_uart_rx_core;

  localparam int BAUD = 52;
  localparam int HALF = BAUD / 2;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       strb;

  int         checks = 0;
  int         failures = 0;
  int         strobe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_core #(
    .UART_BAUD_RATE            (19200),
    .UART_DATA_LENGTH          (8),
    .CLK_FREQ                  (1000000),
    .RX_COUNTER_BITWIDTH       (3),
    .BAUD_COUNTS_PER_BIT       (BAUD),
    .BAUD_RATE_COUNTER_BITWIDTH(10)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .rx_i             (rx),
    .data_o           (data_o),
    .data_valid_strb_o(strb)
  );

  always #5 clk = ~clk;

  // Strobe monitor: every strobe must match the head of the queue. Strobes
  // must also be exactly one cycle wide.
  initial begin
    logic       prev;
    logic [7:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (strb) begin
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe data_o=%h required no strobe", data_o);
        end else begin
          exp = exp_q.pop_front();
          if (data_o !== exp) begin
            failures++;
            $display("FAIL strobe_data data_o=%h required %h", data_o, exp);
          end
        end
        checks++;
        if (prev) begin
          failures++;
          $display("FAIL strobe_width strobe high 2+ cycles, required 1");
        end
      end
      prev = strb;
    end
  end

  // Drives one frame starting at a negedge. Good frames go on the scoreboard.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data data_o=%h required 00", data_o);
    end
    checks++;
    if (strb !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobe strobe=%b required 0", strb);
    end
    reset_i = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt !== 0) begin
      failures++;
      $display("FAIL idle_no_strobe strobes=%0d required 0", strobe_cnt);
    end
  endtask

  task automatic test_single_frame;
    int base;
    base = strobe_cnt;
    send_frame(8'hCC, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 1) begin
      failures++;
      $display("FAIL single_frame strobes=%0d required 1", strobe_cnt - base);
    end
    checks++;
    if (data_o !== 8'hCC) begin
      failures++;
      $display("FAIL single_frame_hold data_o=%h required cc", data_o);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = strobe_cnt;
    for (int n = 0; n < 16; n++) send_frame(8'hCC, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 16) begin
      failures++;
      $display("FAIL back_to_back strobes=%0d required 16", strobe_cnt - base);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL back_to_back_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int base;
    base = strobe_cnt;
    rx = 1'b0;
    repeat (HALF - 16) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL glitch_no_strobe strobes=%0d required 0", strobe_cnt - base);
    end
    send_frame(8'hA5, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 1 || data_o !== 8'hA5) begin
      failures++;
      $display("FAIL glitch_recover strobes=%0d data_o=%h required 1 and a5",
               strobe_cnt - base, data_o);
    end
  endtask

  task automatic test_framing_error;
    int base;
    base = strobe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2 * BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL framing_no_strobe strobes=%0d required 0", strobe_cnt - base);
    end
    checks++;
    if (data_o !== 8'hA5) begin
      failures++;
      $display("FAIL framing_hold data_o=%h required a5", data_o);
    end
    send_frame(8'h5A, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 1) begin
      failures++;
      $display("FAIL framing_recover strobes=%0d required 1", strobe_cnt - base);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    base = strobe_cnt;
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (BAUD) @(negedge clk);
    end
    reset_i = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_i = 1'b0;
    repeat (BAUD) @(negedge clk);
    checks++;
    if (data_o !== 8'h00 || strobe_cnt - base !== 0) begin
      failures++;
      $display("FAIL mid_reset_abort data_o=%h strobes=%0d required 00 and 0",
               data_o, strobe_cnt - base);
    end
    send_frame(8'hFF, 1'b1);
    repeat (BAUD) @(negedge clk);
    checks++;
    if (strobe_cnt - base !== 1 || data_o !== 8'hFF) begin
      failures++;
      $display("FAIL mid_reset_next strobes=%0d data_o=%h required 1 and ff",
               strobe_cnt - base, data_o);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL final_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
